// File: rtl/store_buffer_if.sv
// -----------------------------------------------------------------------------
// store_buffer_if
// Groups the signals between the store buffer, the pipeline MEM stage and the
// word-addressed data memory.
//   Pipeline store : st_valid, st_addr, st_data  -> buffer; st_ready <- buffer
//   Pipeline load  : ld_valid, ld_addr           -> buffer;
//                    ld_fwd_valid, ld_fwd_data   <- buffer (registered)
//   Data memory    : mem_read_enable, mem_write_enable, mem_address,
//                    mem_write_data              <- buffer
//   Status         : empty                       <- buffer
// Modports: slave = store buffer side, master = pipeline/memory side.
// -----------------------------------------------------------------------------
interface store_buffer_if;
    logic        st_valid;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic        ld_fwd_valid;
    logic [31:0] ld_fwd_data;
    logic        mem_read_enable;
    logic        mem_write_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        empty;

    modport slave (
        input  st_valid, st_addr, st_data, ld_valid, ld_addr,
        output st_ready, ld_fwd_valid, ld_fwd_data,
               mem_read_enable, mem_write_enable, mem_address, mem_write_data,
               empty
    );

    modport master (
        output st_valid, st_addr, st_data, ld_valid, ld_addr,
        input  st_ready, ld_fwd_valid, ld_fwd_data,
               mem_read_enable, mem_write_enable, mem_address, mem_write_data,
               empty
    );
endinterface

// File: rtl/store_buffer.sv
// -----------------------------------------------------------------------------
// store_buffer
// Posted-write buffer between the MEM stage and the data memory. Stores enter
// a FIFO and retire to memory whenever no load miss needs the port. Loads are
// forwarded from the youngest matching buffered store, or else issue a
// one-cycle memory read; the forwarded result is registered so both sources
// arrive one cycle after the request.
// Ports:
//   clk   - clock, rising edge
//   reset - synchronous, active-low reset
//   bus   - store_buffer_if.slave (pipeline store/load, memory port, status)
// Parameters:
//   DEPTH - number of buffered stores (power of two, >= 2)
//   PTR_W - log2(DEPTH)
// -----------------------------------------------------------------------------
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic          clk,
    input  logic          reset,
    store_buffer_if.slave bus
);

    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1'b1);
    localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W+1)'(1'b1);
    localparam logic [PTR_W:0]   CNT_FULL   = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ZERO   = (PTR_W+1)'(1'b0);

    logic [31:0]      r_addr [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;
    logic             r_fwd_valid;
    logic [31:0]      r_fwd_data;

    logic             w_hit;
    logic [31:0]      w_fwd;
    logic             w_ld_miss;
    logic             w_drain;
    logic             w_push;
    logic             w_st_ready;
    logic             w_mem_re;
    logic             w_mem_we;
    logic [31:0]      w_mem_addr;
    logic [31:0]      w_mem_wdata;

    assign w_st_ready = (r_count != CNT_FULL);
    assign w_push     = bus.st_valid & w_st_ready;
    assign w_ld_miss  = bus.ld_valid & ~w_hit;
    // A load miss owns the memory port; draining waits for it.
    assign w_drain    = (r_count != CNT_ZERO) & ~w_ld_miss;

    // Search valid entries from oldest to youngest; the last match wins, so the
    // result is the youngest matching store.
    always_comb begin
        logic [PTR_W-1:0] v_idx;
        v_idx = {PTR_W{1'b0}};
        w_hit = 1'b0;
        w_fwd = 32'h0000_0000;
        for (int i = 0; i < DEPTH; i++) begin
            v_idx = r_head + i[PTR_W-1:0];
            if ((i < int'(r_count)) && (r_addr[v_idx][31:2] == bus.ld_addr[31:2])) begin
                w_hit = 1'b1;
                w_fwd = r_data[v_idx];
            end else begin
                w_hit = w_hit;
                w_fwd = w_fwd;
            end
        end
    end

    // Memory port arbitration: held at zero in reset, load miss before drain.
    always_comb begin
        w_mem_re    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = 32'h0000_0000;
        w_mem_wdata = 32'h0000_0000;
        if (!reset) begin
            w_mem_re    = 1'b0;
            w_mem_we    = 1'b0;
        end else if (w_ld_miss) begin
            w_mem_re    = 1'b1;
            w_mem_addr  = bus.ld_addr;
        end else if (w_drain) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = r_addr[r_head];
            w_mem_wdata = r_data[r_head];
        end else begin
            w_mem_re    = 1'b0;
            w_mem_we    = 1'b0;
        end
    end

    // Entry storage; contents need no reset because count qualifies them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_tail] <= bus.st_addr;
            r_data[r_tail] <= bus.st_data;
        end
    end

    // Pointers, occupancy and registered forward result.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_head      <= {PTR_W{1'b0}};
            r_tail      <= {PTR_W{1'b0}};
            r_count     <= CNT_ZERO;
            r_fwd_valid <= 1'b0;
            r_fwd_data  <= 32'h0000_0000;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_ONE;
            end
            if (w_drain) begin
                r_head <= r_head + PTR_ONE;
            end
            case ({w_push, w_drain})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            r_fwd_valid <= bus.ld_valid & w_hit;
            r_fwd_data  <= w_hit ? w_fwd : 32'h0000_0000;
        end
    end

    assign bus.st_ready         = w_st_ready;
    assign bus.empty            = (r_count == CNT_ZERO);
    assign bus.ld_fwd_valid     = r_fwd_valid;
    assign bus.ld_fwd_data      = r_fwd_data;
    assign bus.mem_read_enable  = w_mem_re;
    assign bus.mem_write_enable = w_mem_we;
    assign bus.mem_address      = w_mem_addr;
    assign bus.mem_write_data   = w_mem_wdata;

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the pipeline MEM stage and the word-addressed data memory.
- Stores are accepted into a small FIFO and retire to memory when the memory port is free.
- Loads either forward from the youngest matching buffered store or issue a one-cycle read to memory.
- The forward result is registered so both load sources arrive one cycle after the request, aligned with the memory's registered read data.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, at least 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- st_valid  in  1  pipeline store request.
- st_addr  in  32  store byte address; word-aligned.
- st_data  in  32  store data.
- st_ready  out  1  buffer can accept a store; equals (count != DEPTH).
- ld_valid  in  1  pipeline load request.
- ld_addr  in  32  load byte address; word-aligned.
- ld_fwd_valid  out  1  registered; previous-cycle load was served from the buffer.
- ld_fwd_data  out  32  registered forwarded data.
- mem_read_enable  out  1  to data memory.
- mem_write_enable  out  1  to data memory.
- mem_address  out  32  to data memory.
- mem_write_data  out  32  to data memory.
- empty  out  1  count == 0.

Behaviour:
- State:
  - entry arrays addr[DEPTH] and data[DEPTH].
  - head and tail pointers, PTR_W bits each, wrapping modulo DEPTH.
  - count, PTR_W+1 bits.
- Reset (reset==0 at a clock edge):
  - head = tail = count = 0.
  - ld_fwd_valid = 0, ld_fwd_data = 0.
  - Entry contents are don't-care.
  - While reset==0, the mem_* outputs are forced to 0.
  - Reset mid-drain discards all pending stores.
- Match rule:
  - Compare addr[31:2] against every valid entry.
  - Valid entries are the count entries starting at head.
  - hit = any match; on a hit, fwd = data of the youngest match (closest to tail).
- Load, combinational in the request cycle:
  - ld_valid & hit: no memory read.
  - ld_valid & !hit: mem_read_enable = 1, mem_address = ld_addr, mem_write_enable = 0.
- Load, next edge:
  - ld_fwd_valid <= ld_valid & hit.
  - ld_fwd_data <= hit ? fwd : 0.
  - The consumer takes ld_fwd_data when ld_fwd_valid is set, otherwise memory data.
  - Latency is 1 cycle for both paths.
- Drain, combinational:
  - Drains when count != 0 and not (ld_valid & !hit).
  - A load miss has priority over a drain.
  - Drain outputs: mem_write_enable = 1, mem_address = addr[head], mem_write_data = data[head].
  - Otherwise mem_write_enable = 0, mem_address = 0, mem_write_data = 0.
  - mem_read_enable and mem_write_enable are never both 1.
- Drain, edge: head <= head+1.
- Push: st_valid & st_ready at the edge writes entry[tail] and sets tail <= tail+1.
- st_valid & !st_ready: the store is dropped; the pipeline must hold it.
- Count update: count <= count + push − drain; a simultaneous push and drain leaves count unchanged.
- st_ready is computed from the current count only; a full buffer refuses the store even if a drain occurs in the same cycle.
- Same-cycle store and load:
  - The load matches only entries present before the edge.
  - A store pushed that cycle is not forwarded to that load.
- Forwarding from the head entry is still valid in the cycle that entry drains (pre-edge contents).
- Wrap-around: pointers wrap DEPTH−1 → 0 with no bubble.
- No coalescing: repeated stores to one address occupy separate entries and drain in order.

Test Plan:
- Reset low 2 cycles, then high:
  - empty = 1, st_ready = 1, ld_fwd_valid = 0, and all mem_* are 0.
- Store 0x8 ← 0xAAAA_0001, no loads:
  - Next cycle: mem_write_enable = 1, mem_address = 0x8, mem_write_data = 0xAAAA_0001.
  - Following cycle: empty = 1.
- Hold ld_valid to 0x20 (miss) every cycle while pushing 4 stores:
  - st_ready = 0 after the 4th push; a 5th store is refused.
  - No mem_write_enable while the loads persist.
- Release the load:
  - The 4 stores drain in order on consecutive cycles, then empty = 1.
- Stores to 0x4 of 0x11 then 0x22; load 0x4 with the port held by load misses:
  - Next cycle: ld_fwd_valid = 1, ld_fwd_data = 0x22, and no mem_read_enable in the request cycle.
- Load 0xC not buffered:
  - Request cycle: mem_read_enable = 1, mem_address = 0xC.
  - Next cycle: ld_fwd_valid = 0.
- 10 push/drain cycles to exercise wrap-around, then reset low mid-stream:
  - Drain order is preserved across the wrap.
  - After reset: empty = 1, and the discarded stores never appear on mem_write_enable.
